pll_lock_supervisor: RTL and testbench

- Sits on the reference-clock side of the PLL wrapper and consumes its `locked` output.
- Drives the PLL's `rst` input and produces a clean system reset request once lock is stable.
- Detects loss of lock or lock timeout, then re-resets the PLL and retries.
- Exposes retry and lock-loss status for debug, e.g. on LEDs or a status register.

---
 rtl/pll_lock_supervisor.sv | 116 +++++++++++
 tb/tb_pll_lock_supervisor.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for a stable lock, then releases the
// system reset. Loss of lock or a lock timeout re-resets the PLL and bumps a retry counter.
module pll_lock_supervisor #(
    parameter int unsigned RST_CYCLES          = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter int unsigned CNT_W               = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             locked_async,
    input  logic             clear_status,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic [CNT_W-1:0] retry_cnt,
    output logic             lock_lost
);

    localparam int unsigned MAX_A   = (RST_CYCLES > LOCK_STABLE_CYCLES) ? RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_CYC);

    localparam logic [CW-1:0]    RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0]    STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0]    TO_LAST     = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RETRY_MAX   = '1;

    typedef enum logic [1:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RUN
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_next;
    logic             r_sync1;
    logic             r_locked_s;
    logic             w_retry_evt;
    logic             w_lost_evt;
    logic [CNT_W-1:0] w_retry_next;
    logic             w_lost_next;

    always_comb begin
        w_next      = r_state;
        w_cnt_next  = r_cnt + CW'(1);
        w_retry_evt = 1'b0;
        w_lost_evt  = 1'b0;
        case (r_state)
            PLL_RST: begin
                if (r_cnt == RST_LAST) w_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (r_locked_s) begin
                    w_next = STABLE;
                end else if (r_cnt == TO_LAST) begin
                    w_next      = PLL_RST;
                    w_retry_evt = 1'b1;
                end
            end
            STABLE: begin
                if (!r_locked_s) w_next = WAIT_LOCK;
                else if (r_cnt == STABLE_LAST) w_next = RUN;
            end
            RUN: begin
                w_cnt_next = '0;
                if (!r_locked_s) begin
                    w_next      = PLL_RST;
                    w_retry_evt = 1'b1;
                    w_lost_evt  = 1'b1;
                end
            end
            default: w_next = PLL_RST;
        endcase
        if (w_next != r_state) w_cnt_next = '0;
    end

    // A retry or loss event on the same edge as clear_status takes priority over the clear.
    always_comb begin
        w_retry_next = retry_cnt;
        if (clear_status) begin
            w_retry_next = w_retry_evt ? CNT_W'(1) : '0;
        end else if (w_retry_evt && (retry_cnt != RETRY_MAX)) begin
            w_retry_next = retry_cnt + CNT_W'(1);
        end
        w_lost_next = w_lost_evt | (lock_lost & ~clear_status);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state    <= PLL_RST;
            r_cnt      <= '0;
            r_sync1    <= 1'b0;
            r_locked_s <= 1'b0;
            pll_rst    <= 1'b1;
            sys_rst    <= 1'b1;
            ready      <= 1'b0;
            retry_cnt  <= '0;
            lock_lost  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_cnt      <= w_cnt_next;
            r_sync1    <= locked_async;
            r_locked_s <= r_sync1;
            pll_rst    <= (w_next == PLL_RST);
            sys_rst    <= (w_next != RUN);
            ready      <= (w_next == RUN);
            retry_cnt  <= w_retry_next;
            lock_lost  <= w_lost_next;
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: bring-up vector table, directed corner sequences and
// randomized lock behaviour compared against a cycle-level reference model.
module tb_pll_lock_supervisor;

    localparam int unsigned RC = 4;
    localparam int unsigned LS = 8;
    localparam int unsigned TO = 20;
    localparam int unsigned CW = 4;
    localparam int RETRY_SAT = (1 << CW) - 1;

    logic          refclk = 1'b0;
    logic          rst;
    logic          locked_async;
    logic          clear_status;
    logic          pll_rst;
    logic          sys_rst;
    logic          ready;
    logic [CW-1:0] retry_cnt;
    logic          lock_lost;

    always #5 refclk = ~refclk;

    pll_lock_supervisor #(
        .RST_CYCLES(RC),
        .LOCK_STABLE_CYCLES(LS),
        .LOCK_TIMEOUT_CYCLES(TO),
        .CNT_W(CW)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .locked_async(locked_async),
        .clear_status(clear_status),
        .pll_rst(pll_rst),
        .sys_rst(sys_rst),
        .ready(ready),
        .retry_cnt(retry_cnt),
        .lock_lost(lock_lost)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic d_rst = 1'b1;
    logic d_la  = 1'b0;
    logic d_clr = 1'b0;

    // Reference model: remaining PLL reset cycles, cycles spent waiting, consecutive
    // good-lock cycles, running flag, and a two-deep history of the lock input.
    int m_pll_left = RC;
    int m_waited   = 0;
    int m_good     = 0;
    bit m_up       = 1'b0;
    int m_retry    = 0;
    bit m_lost     = 1'b0;
    bit lhist[$]   = '{1'b0, 1'b0};

    typedef struct {
        bit rst;
        bit la;
        bit clr;
        bit pll;
        bit sys;
        bit rdy;
        int retry;
        bit lost;
    } vec_t;

    vec_t tbl[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit seen;
        bit inc;
        bit setl;
        inc  = 1'b0;
        setl = 1'b0;
        if (d_rst) begin
            m_pll_left = RC;
            m_waited   = 0;
            m_good     = 0;
            m_up       = 1'b0;
            m_retry    = 0;
            m_lost     = 1'b0;
            lhist      = '{1'b0, 1'b0};
            return;
        end
        seen = lhist.pop_front();
        lhist.push_back(d_la);
        if (m_pll_left > 0) begin
            m_pll_left--;
            if (m_pll_left == 0) m_waited = 0;
        end else if (m_up) begin
            if (!seen) begin
                m_up       = 1'b0;
                m_pll_left = RC;
                inc        = 1'b1;
                setl       = 1'b1;
            end
        end else if (m_good > 0) begin
            if (!seen) begin
                m_good   = 0;
                m_waited = 0;
            end else if (m_good == LS) begin
                m_good = 0;
                m_up   = 1'b1;
            end else begin
                m_good++;
            end
        end else begin
            if (seen) m_good = 1;
            else if (m_waited == TO - 1) begin
                m_pll_left = RC;
                inc        = 1'b1;
            end else m_waited++;
        end
        if (d_clr) begin
            m_retry = 0;
            m_lost  = 1'b0;
        end
        if (inc && m_retry < RETRY_SAT) m_retry++;
        if (setl) m_lost = 1'b1;
    endtask

    task automatic step(input bit use_model);
        @(negedge refclk);
        rst          = d_rst;
        locked_async = d_la;
        clear_status = d_clr;
        @(posedge refclk);
        model_edge();
        #1;
        if (use_model) begin
            check("model pll_rst", pll_rst, m_pll_left > 0);
            check("model sys_rst", sys_rst, !m_up);
            check("model ready", ready, m_up);
            check("model retry_cnt", retry_cnt, m_retry);
            check("model lock_lost", lock_lost, m_lost);
        end
    endtask

    task automatic edges_until_ready(input int limit, output int n);
        n = 0;
        do begin
            step(1'b1);
            n++;
        end while (!ready && n < limit);
    endtask

    task automatic edges_until_sysrst(input int limit, output int n);
        n = 0;
        do begin
            step(1'b1);
            n++;
        end while (!sys_rst && n < limit);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit saw_sys_low;
        rst          = 1'b1;
        locked_async = 1'b0;
        clear_status = 1'b0;

        // Clean bring-up: lock input rises on vector 7, ready 10 edges later.
        for (int i = 0; i < 20; i++) begin
            tbl[i].rst   = (i == 0);
            tbl[i].la    = (i >= 7);
            tbl[i].clr   = 1'b0;
            tbl[i].pll   = (i <= 3);
            tbl[i].sys   = (i < 17);
            tbl[i].rdy   = (i >= 17);
            tbl[i].retry = 0;
            tbl[i].lost  = 1'b0;
        end
        for (int i = 0; i < 20; i++) begin
            d_rst = tbl[i].rst;
            d_la  = tbl[i].la;
            d_clr = tbl[i].clr;
            step(1'b0);
            check($sformatf("tbl[%0d] pll_rst", i), pll_rst, tbl[i].pll);
            check($sformatf("tbl[%0d] sys_rst", i), sys_rst, tbl[i].sys);
            check($sformatf("tbl[%0d] ready", i), ready, tbl[i].rdy);
            check($sformatf("tbl[%0d] retry_cnt", i), retry_cnt, tbl[i].retry);
            check($sformatf("tbl[%0d] lock_lost", i), lock_lost, tbl[i].lost);
        end

        // Timeout: no lock ever, 24-cycle retry period, saturation at 15.
        d_rst = 1'b1;
        d_la  = 1'b0;
        step(1'b1);
        d_rst = 1'b0;
        saw_sys_low = 1'b0;
        for (int k = 1; k <= 24 * 20; k++) begin
            step(1'b1);
            if (!sys_rst) saw_sys_low = 1'b1;
            check("timeout pll_rst period", pll_rst, (k % 24) < 4);
            if (k % 24 == 0) check("timeout retry count", retry_cnt, (k / 24 > 15) ? 15 : k / 24);
        end
        check("timeout retry saturated", retry_cnt, 15);
        check("timeout sys_rst never low", saw_sys_low, 1'b0);

        // Lock chatter in STABLE at cnt=5: no retry, ready 10 edges after re-rise.
        d_rst = 1'b1;
        step(1'b1);
        d_rst = 1'b0;
        repeat (4) step(1'b1);
        d_la = 1'b1;
        repeat (6) step(1'b1);
        d_la = 1'b0;
        step(1'b1);
        d_la = 1'b1;
        step(1'b1);
        edges_until_ready(40, n);
        check("chatter ready latency", n, 10);
        check("chatter retry_cnt", retry_cnt, 0);

        // Loss of lock in RUN.
        d_la = 1'b0;
        step(1'b1);
        edges_until_sysrst(10, n);
        check("loss sys_rst latency", n, 2);
        check("loss pll_rst", pll_rst, 1'b1);
        check("loss ready", ready, 1'b0);
        check("loss lock_lost", lock_lost, 1'b1);
        check("loss retry_cnt", retry_cnt, 1);
        step(1'b1);
        d_la = 1'b1;
        edges_until_ready(60, n);
        check("loss relock ready", ready, 1'b1);

        // Clear coinciding with a RUN loss, then a lone clear.
        d_la = 1'b0;
        step(1'b1);
        step(1'b1);
        d_clr = 1'b1;
        step(1'b1);
        d_clr = 1'b0;
        check("collision retry_cnt", retry_cnt, 1);
        check("collision lock_lost", lock_lost, 1'b1);
        check("collision sys_rst", sys_rst, 1'b1);
        d_la = 1'b1;
        repeat (3) step(1'b1);
        d_clr = 1'b1;
        step(1'b1);
        d_clr = 1'b0;
        check("lone clear retry_cnt", retry_cnt, 0);
        check("lone clear lock_lost", lock_lost, 1'b0);
        edges_until_ready(60, n);
        check("clear relock ready", ready, 1'b1);

        // Reset mid-RUN with status set; ready returns 13 edges after the reset edge.
        d_la = 1'b0;
        repeat (3) step(1'b1);
        d_la = 1'b1;
        edges_until_ready(60, n);
        check("pre-reset lock_lost", lock_lost, 1'b1);
        d_rst = 1'b1;
        step(1'b1);
        d_rst = 1'b0;
        check("midrun reset pll_rst", pll_rst, 1'b1);
        check("midrun reset sys_rst", sys_rst, 1'b1);
        check("midrun reset ready", ready, 1'b0);
        check("midrun reset retry_cnt", retry_cnt, 0);
        check("midrun reset lock_lost", lock_lost, 1'b0);
        edges_until_ready(60, n);
        check("midrun reset ready latency", n, 13);

        // Randomized lock behaviour with occasional clears and resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 5) d_la = ~d_la;
            d_clr = ($urandom_range(0, 99) < 3);
            d_rst = ($urandom_range(0, 999) < 4);
            step(1'b1);
            check("invariant sys_rst^ready", sys_rst ^ ready, 1'b1);
        end
        d_rst = 1'b0;
        d_clr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
